// File: rtl/bp_me_dev_router.sv
// bp_me_dev_router: steers IO commands to local devices or memory, merges responses in order.
// Ports: cmd_* (in), dev_* (per-channel out), dev_resp_* (in), resp_*/outstanding_o (out).
// Macro BP_DEV_ROUTER_ERR_RESP_EN: unmapped commands get an internal error response.
module bp_me_dev_router #(
  parameter int paddr_width_p     = 40,
  parameter int data_width_p      = 64,
  parameter int num_dev_p         = 5,
  parameter int max_outstanding_p = 4
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    cmd_v_i,
  output logic                                    cmd_ready_o,
  input  logic [paddr_width_p-1:0]                cmd_addr_i,
  input  logic [data_width_p-1:0]                 cmd_data_i,
  input  logic                                    cmd_we_i,
  output logic [num_dev_p:0]                      dev_v_o,
  input  logic [num_dev_p:0]                      dev_ready_i,
  output logic [paddr_width_p-1:0]                dev_addr_o,
  output logic [data_width_p-1:0]                 dev_data_o,
  output logic                                    dev_we_o,
  input  logic [num_dev_p:0]                      dev_resp_v_i,
  output logic [num_dev_p:0]                      dev_resp_ready_o,
  input  logic [(num_dev_p+1)*data_width_p-1:0]   dev_resp_data_i,
  output logic                                    resp_v_o,
  input  logic                                    resp_ready_i,
  output logic [data_width_p-1:0]                 resp_data_o,
  output logic                                    resp_err_o,
  output logic [$clog2(max_outstanding_p+1)-1:0]  outstanding_o
);

  localparam int chan_lp  = num_dev_p + 1;
  localparam int tag_w_lp = $clog2(chan_lp + 1);
  localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);

  typedef logic [tag_w_lp-1:0] tag_t;

  localparam tag_t err_tag_lp = tag_t'(chan_lp);
  localparam tag_t mem_tag_lp = tag_t'(num_dev_p);
`ifdef BP_DEV_ROUTER_ERR_RESP_EN
  localparam tag_t unmap_tag_lp = err_tag_lp;
`else
  localparam tag_t unmap_tag_lp = mem_tag_lp;
`endif

  typedef enum logic {E_EMPTY, E_HELD} state_e;

  state_e                    state_q, state_d;
  logic [paddr_width_p-1:0]  addr_q, addr_d;
  logic [data_width_p-1:0]   data_q, data_d;
  logic                      we_q, we_d;
  tag_t                      tag_q, tag_d;
  tag_t                      fifo_q [max_outstanding_p];
  tag_t                      fifo_d [max_outstanding_p];
  logic [ptr_w_lp-1:0]       wr_ptr_q, wr_ptr_d;
  logic [ptr_w_lp-1:0]       rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0]       cnt_q, cnt_d;

  logic [3:0] dec_id;
  logic       dec_mem;
  logic       dec_dev;
  tag_t       dec_tag;
  tag_t       head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       head_err;
  logic       tag_err;
  logic       held;
  logic       pop;
  logic       room;
  logic       dispatch;
  logic       accept;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode of the incoming command.
  always_comb begin
    dec_id  = cmd_addr_i[23:20];
    dec_mem = |cmd_addr_i[paddr_width_p-1:31];
    dec_dev = ~|cmd_addr_i[paddr_width_p-1:24]
              && ({1'b0, dec_id} < 5'(num_dev_p));
    dec_tag = unmap_tag_lp;
    unique case (1'b1)
      dec_mem: dec_tag = mem_tag_lp;
      dec_dev: dec_tag = tag_t'(dec_id);
      default: dec_tag = unmap_tag_lp;
    endcase
  end

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == cnt_w_lp'(max_outstanding_p));
    head       = fifo_q[rd_ptr_q];
    head_err   = !fifo_empty && (head == err_tag_lp);

    // Response merge: only the channel at the FIFO head may complete.
    resp_v_o         = 1'b0;
    resp_data_o      = '0;
    dev_resp_ready_o = '0;
    if (head_err) begin
      resp_v_o = 1'b1;
    end else if (!fifo_empty) begin
      for (int k = 0; k < chan_lp; k++) begin
        if (head == tag_t'(k)) begin
          resp_v_o            = dev_resp_v_i[k];
          resp_data_o         = dev_resp_data_i[k*data_width_p +: data_width_p];
          dev_resp_ready_o[k] = resp_ready_i;
        end
      end
    end
    pop = resp_v_o & resp_ready_i;

    // A pop frees a slot in the same cycle, so a full FIFO never stalls a drain.
    held    = (state_q == E_HELD);
    room    = !fifo_full | pop;
    tag_err = (tag_q == err_tag_lp);
    dev_v_o = '0;
    for (int k = 0; k < chan_lp; k++) begin
      if (tag_q == tag_t'(k)) dev_v_o[k] = held & !tag_err & room;
    end
    dispatch    = held & room & (tag_err | (|(dev_v_o & dev_ready_i)));
    cmd_ready_o = !held | dispatch;
    accept      = cmd_v_i & cmd_ready_o;

    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    tag_d   = tag_q;
    if (accept) begin
      state_d = E_HELD;
      addr_d  = cmd_addr_i;
      data_d  = cmd_data_i;
      we_d    = cmd_we_i;
      tag_d   = dec_tag;
    end else if (dispatch) begin
      state_d = E_EMPTY;
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (dispatch) begin
      fifo_d[wr_ptr_q] = tag_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    unique case ({dispatch, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef BP_DEV_ROUTER_ERR_RESP_EN
  assign resp_err_o = head_err;
`else
  assign resp_err_o = 1'b0;
`endif

  assign dev_addr_o    = addr_q;
  assign dev_data_o    = data_q;
  assign dev_we_o      = we_q;
  assign outstanding_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= E_EMPTY;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      tag_q    <= '0;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      tag_q    <= tag_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bp_me_dev_router.sv
// tb_bp_me_dev_router: directed bench with a transaction-level order model.
// Build with or without BP_DEV_ROUTER_ERR_RESP_EN to match the RTL.
module tb_bp_me_dev_router;
  localparam int PW = 40;
  localparam int DW = 64;
  localparam int ND = 5;
  localparam int MO = 2;
  localparam int CH = ND + 1;
  localparam int OW = $clog2(MO + 1);

  logic           clk = 1'b0;
  logic           reset_n_i;
  logic           cmd_v_i;
  logic           cmd_ready_o;
  logic [PW-1:0]  cmd_addr_i;
  logic [DW-1:0]  cmd_data_i;
  logic           cmd_we_i;
  logic [CH-1:0]  dev_v_o;
  logic [CH-1:0]  dev_ready_i;
  logic [PW-1:0]  dev_addr_o;
  logic [DW-1:0]  dev_data_o;
  logic           dev_we_o;
  logic [CH-1:0]  dev_resp_v_i;
  logic [CH-1:0]  dev_resp_ready_o;
  logic [CH*DW-1:0] dev_resp_data_i;
  logic           resp_v_o;
  logic           resp_ready_i;
  logic [DW-1:0]  resp_data_o;
  logic           resp_err_o;
  logic [OW-1:0]  outstanding_o;

  always #5 clk = ~clk;

  bp_me_dev_router #(
    .paddr_width_p(PW), .data_width_p(DW),
    .num_dev_p(ND), .max_outstanding_p(MO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_we_i(cmd_we_i),
    .dev_v_o(dev_v_o), .dev_ready_i(dev_ready_i),
    .dev_addr_o(dev_addr_o), .dev_data_o(dev_data_o), .dev_we_o(dev_we_o),
    .dev_resp_v_i(dev_resp_v_i), .dev_resp_ready_o(dev_resp_ready_o),
    .dev_resp_data_i(dev_resp_data_i),
    .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .outstanding_o(outstanding_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Channel for an address; -1 marks an unmapped command with error response.
  function automatic int route(input logic [PW-1:0] a);
    longint unsigned v;
    v = 64'(a);
    if (v >= 64'h8000_0000) return ND;
    if (v < 64'h100_0000 && (v / 64'h10_0000) < ND)
      return int'(v / 64'h10_0000);
`ifdef BP_DEV_ROUTER_ERR_RESP_EN
    return -1;
`else
    return ND;
`endif
  endfunction

  bit            m_armed = 0;
  bit            m_held = 0;
  int            m_ch = 0;
  logic [PW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  logic          m_we = 1'b0;
  int            m_q[$];

  always @(negedge clk) begin
    int            h;
    bit            pop, room, disp, e_rv, e_err, e_cr;
    logic [DW-1:0] e_rd;
    logic [CH-1:0] e_rr, e_dv;
    h     = (m_q.size() > 0) ? m_q[0] : -2;
    e_err = (h == -1);
    e_rv  = e_err || (h >= 0 && dev_resp_v_i[h]);
    e_rd  = (h >= 0) ? dev_resp_data_i[h*DW +: DW] : '0;
    e_rr  = (h >= 0 && resp_ready_i) ? (CH'(1) << h) : '0;
    pop   = e_rv && resp_ready_i;
    room  = (m_q.size() < MO) || pop;
    e_dv  = (m_held && m_ch >= 0 && room) ? (CH'(1) << m_ch) : '0;
    disp  = m_held && room && (m_ch < 0 || dev_ready_i[m_ch]);
    e_cr  = !m_held || disp;
    if (m_armed) begin
      chk("cmd_ready", cmd_ready_o, e_cr);
      chk("dev_v", dev_v_o, e_dv);
      chk("dev_addr", dev_addr_o, m_addr);
      chk("dev_data", dev_data_o, m_data);
      chk("dev_we", dev_we_o, m_we);
      chk("resp_v", resp_v_o, e_rv);
      chk("resp_err", resp_err_o, e_err);
      chk("resp_data", resp_data_o, e_rd);
      chk("dev_resp_ready", dev_resp_ready_o, e_rr);
      chk("outstanding", outstanding_o, m_q.size());
    end
    if (!reset_n_i) begin
      m_armed = 1;
      m_held  = 0;
      m_addr  = '0;
      m_data  = '0;
      m_we    = 1'b0;
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (disp) m_q.push_back(m_ch);
      if (cmd_v_i && e_cr) begin
        m_held = 1;
        m_ch   = route(cmd_addr_i);
        m_addr = cmd_addr_i;
        m_data = cmd_data_i;
        m_we   = cmd_we_i;
      end else if (disp) begin
        m_held = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  int nd;

  initial begin
    reset_n_i       = 1'b0;
    cmd_v_i         = 1'b0;
    cmd_addr_i      = '0;
    cmd_data_i      = '0;
    cmd_we_i        = 1'b0;
    dev_ready_i     = '1;
    dev_resp_v_i    = '0;
    dev_resp_data_i = '0;
    resp_ready_i    = 1'b1;
    repeat (3) tick();
    reset_n_i = 1'b1;
    neg();
    chk("rst_cmd_ready", cmd_ready_o, 1);
    chk("rst_dev_v", dev_v_o, 0);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_dev_resp_ready", dev_resp_ready_o, 0);

    // clint access and response
    tick(); cmd_v_i = 1; cmd_addr_i = 'h30_bff8; cmd_we_i = 0;
    tick(); cmd_v_i = 0;
    neg(); chk("t1_dev_v", dev_v_o, 6'b001000);
    tick(); dev_resp_v_i = 6'b001000;
    dev_resp_data_i[3*DW +: DW] = 64'h1234;
    neg();
    chk("t1_resp_v", resp_v_o, 1);
    chk("t1_resp_data", resp_data_o, 64'h1234);
    chk("t1_out1", outstanding_o, 1);
    tick(); dev_resp_v_i = '0;
    neg(); chk("t1_out0", outstanding_o, 0);

    // cfg then memory; memory answers first and must wait
    tick(); cmd_v_i = 1; cmd_addr_i = 'h20_0000; cmd_we_i = 1;
    cmd_data_i = 64'hd0;
    tick(); cmd_addr_i = 'h8000_0000; cmd_data_i = 64'hd1;
    neg(); chk("t2_dev_v_cfg", dev_v_o, 6'b000100);
    tick(); cmd_v_i = 0;
    neg(); chk("t2_dev_v_mem", dev_v_o, 6'b100000);
    tick(); dev_resp_v_i = 6'b100000;
    dev_resp_data_i[5*DW +: DW] = 64'hbbbb;
    neg();
    chk("t2_mem_blocked", dev_resp_ready_o, 6'b000100);
    chk("t2_no_resp", resp_v_o, 0);
    chk("t2_out2", outstanding_o, 2);
    tick(); neg(); chk("t2_mem_still", dev_resp_ready_o, 6'b000100);
    tick(); dev_resp_v_i = 6'b100100;
    dev_resp_data_i[2*DW +: DW] = 64'haaaa;
    neg(); chk("t2_first_cfg", resp_data_o, 64'haaaa);
    tick(); dev_resp_v_i = 6'b100000;
    neg();
    chk("t2_then_mem", resp_data_o, 64'hbbbb);
    chk("t2_mem_ready", dev_resp_ready_o, 6'b100000);
    tick(); dev_resp_v_i = '0;
    neg(); chk("t2_out0", outstanding_o, 0);

    // unmapped device slot
    tick(); cmd_v_i = 1; cmd_addr_i = 'h70_0000; cmd_we_i = 0;
    tick(); cmd_v_i = 0;
    neg();
`ifdef BP_DEV_ROUTER_ERR_RESP_EN
    chk("t3_no_dev_v", dev_v_o, 0);
    tick(); neg();
    chk("t3_err_v", resp_v_o, 1);
    chk("t3_err", resp_err_o, 1);
    chk("t3_err_data", resp_data_o, 0);
    tick(); neg();
`else
    chk("t3_to_mem", dev_v_o, 6'b100000);
    tick(); dev_resp_v_i = 6'b100000;
    dev_resp_data_i[5*DW +: DW] = 64'h77;
    neg();
    chk("t3_resp_v", resp_v_o, 1);
    chk("t3_no_err", resp_err_o, 0);
    tick(); dev_resp_v_i = '0;
    neg();
`endif
    chk("t3_out0", outstanding_o, 0);

    // order FIFO full, then drain with dispatch in the pop cycle
    tick(); resp_ready_i = 0; cmd_v_i = 1; cmd_addr_i = 'h8000_0100;
    tick(); cmd_addr_i = 'h8000_0200;
    tick(); cmd_addr_i = 'h8000_0300;
    tick(); cmd_v_i = 0;
    neg();
    chk("t4_cmd_ready", cmd_ready_o, 0);
    chk("t4_dev_v", dev_v_o, 0);
    chk("t4_out", outstanding_o, 2);
    tick(); neg(); chk("t4_stall", dev_v_o, 0);
    tick(); resp_ready_i = 1; dev_resp_v_i = 6'b100000;
    dev_resp_data_i[5*DW +: DW] = 64'h55;
    neg();
    chk("t4_pop_v", resp_v_o, 1);
    chk("t4_disp", dev_v_o, 6'b100000);
    chk("t4_ready", cmd_ready_o, 1);
    tick(); neg(); chk("t4_out_same", outstanding_o, 2);
    tick(); neg(); chk("t4_out1", outstanding_o, 1);
    tick(); dev_resp_v_i = '0;
    neg(); chk("t4_out0", outstanding_o, 0);

    // 8 back-to-back memory commands
    nd = 0;
    tick(); dev_resp_v_i = 6'b100000;
    for (int i = 0; i < 8; i++) begin
      cmd_v_i = 1;
      cmd_addr_i = PW'(64'h8000_1000 + i * 8);
      cmd_data_i = 64'(i);
      neg();
      if (i > 0) begin
        chk("t5_dev_v", dev_v_o, 6'b100000);
        if (dev_v_o[5] && dev_ready_i[5]) nd++;
      end
      tick();
    end
    cmd_v_i = 0;
    neg();
    chk("t5_dev_v_last", dev_v_o, 6'b100000);
    if (dev_v_o[5] && dev_ready_i[5]) nd++;
    chk("t5_dispatches", nd, 8);
    tick(); tick(); dev_resp_v_i = '0;
    neg(); chk("t5_out0", outstanding_o, 0);

    // reset with two commands in flight
    tick(); resp_ready_i = 0; cmd_v_i = 1; cmd_addr_i = 'h8000_2000;
    tick(); cmd_addr_i = 'h8000_2008;
    tick(); cmd_v_i = 0;
    tick(); neg(); chk("t6_out2", outstanding_o, 2);
    tick(); reset_n_i = 0; dev_resp_v_i = 6'b100000;
    tick(); neg();
    chk("t6_out0", outstanding_o, 0);
    chk("t6_dev_v", dev_v_o, 0);
    chk("t6_cmd_ready", cmd_ready_o, 1);
    chk("t6_resp_v", resp_v_o, 0);
    tick(); reset_n_i = 1; resp_ready_i = 1;
    neg(); chk("t6_no_accept", dev_resp_ready_o, 0);
    tick(); dev_resp_v_i = '0;
    neg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
